sys_irq_ctrl: RTL and testbench
===============================

# sys_irq_ctrl

Interrupt aggregator directly downstream of the system clock timer and the other Avalon-MM peripherals. It collects up to 16 peripheral `irq` lines, latches edge-type events, and masks them. It drives a single registered `cpu_irq` to the processor plus the lowest-numbered active source ID. Software services it through a 16-bit Avalon-MM slave with the same register timing as the timer's `s1` port.

## Interface

Parameters:
- `NUM_IRQ`, default 8: number of interrupt inputs, legal range 1..16; bits at and above `NUM_IRQ` read 0 and ignore writes.

Ports:
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `address` input 3: register select.
- `chipselect` input 1: slave select.
- `write_n` input 1: active-low write strobe; a write occurs when `chipselect && ~write_n`.
- `writedata` input 16: write data.
- `readdata` output 16: registered read data.
- `irq_in` input NUM_IRQ: peripheral interrupt lines, synchronous to `clk`; bit 0 is the timer's `irq`.
- `cpu_irq` output 1: registered OR of enabled pending sources.
- `irq_id` output 4: registered index of the lowest-numbered enabled pending source; 0 when none.

## Operation

Register map (16-bit, unmapped bits read 0):
- **0 PENDING**
  - Read: pending bits.
  - Write: 1 clears edge-mode bits. Writes to level-mode bits are ignored.
- **1 ENABLE**: read/write mask; reset 0.
- **2 EDGE_SEL**: read/write; 1 = rising-edge latched, 0 = level; reset 0.
- **3 ACTIVE**: read-only `{valid, 11'b0, id[3:0]}`.
  - valid = any bit of (PENDING & ENABLE) is set.
  - id = lowest set index.
- **4 OVERRUN**
  - Read: overrun bits, set when a rising edge arrives on an edge-mode line whose PENDING bit is already 1.
  - Write: 1 clears.
- **5 FORCE**: write 1 sets the PENDING bit of an edge-mode line (software trigger); reads 0.
- **6, 7**: reserved; read 0, writes ignored.

Input processing:
- `irq_d` is a one-cycle registered copy of `irq_in`; `rise = irq_in & ~irq_d`.
- **Edge-mode line i**:
  - Set PENDING[i] when rise[i] or a FORCE write of 1.
  - Otherwise clear it when a PENDING write of 1 hits it.
  - If set and clear hit the same cycle, set wins and the bit stays 1.
- **Level-mode line i**: PENDING[i] <= irq_in[i] every cycle.
- **OVERRUN[i]**: set when rise[i] && PENDING[i] && EDGE_SEL[i]. On a simultaneous set and W1C, set wins.
- **Changing EDGE_SEL[i] from 0 to 1**:
  - PENDING[i] keeps its current value.
  - No edge is synthesised from a line that is already high.
- **Disabled lines** (ENABLE=0) still latch PENDING/OVERRUN; they only stop driving `cpu_irq`/`irq_id`.

Outputs:
- `cpu_irq <= |(PENDING & ENABLE)`, registered.
- `irq_id <=` priority-encode of (PENDING & ENABLE), registered; 0 when none.
- `readdata <=` mux(address) every clock, regardless of `chipselect`. This matches the timer.

## Timing

Reset (synchronous, `reset`=1 at a rising edge):
- All registers, `irq_d`, `readdata`, `cpu_irq` and `irq_id` become 0.
- An `irq_in` that is high when reset releases does not produce an edge event, because `irq_d` is reloaded on the first active cycle before edges are evaluated.

Latency:
- **Edge path**:
  - `irq_in` rises before clock edge k, so PENDING is set at k.
  - `cpu_irq`/`irq_id` update at k+1.
  - Readable at address 0 with `readdata` valid after edge k+1, from a read issued in cycle k+1.
- **Level path**:
  - PENDING follows `irq_in` with 1 cycle lag.
  - `cpu_irq` follows with 2 cycles lag, both on assertion and deassertion.
- **Read**: 1 cycle. `readdata` after edge n reflects address and register state sampled at edge n.
- **W1C**:
  - The write at edge n clears PENDING at n.
  - `cpu_irq` drops at n+1, unless a new edge sets the bit at n.
- **ENABLE write** at edge n affects `cpu_irq` at n+1.

## Test plan

- **Edge latch and clear**: EDGE_SEL=1, ENABLE=1, pulse `irq_in[0]` high for 1 cycle at edge k -> PENDING=0x0001 at k; `cpu_irq`=1, `irq_id`=0 at k+1; write 0x0001 to addr 0 -> `cpu_irq`=0 the cycle after.
- **Priority**: edge mode on lines 2 and 5, ENABLE=0x0024, pulse both together -> ACTIVE reads 0x8002; clear bit 2 -> ACTIVE reads 0x8005; clear bit 5 -> ACTIVE 0x0000 and `cpu_irq`=0.
- **Overrun and set-wins**: pulse line 0 twice without clearing -> OVERRUN=0x0001. Write W1C to PENDING in the same cycle as a third rising edge -> PENDING stays 0x0001.
- **Level mode and mask**: EDGE_SEL=0, ENABLE=0, hold `irq_in[3]`=1 -> PENDING=0x0008 and `cpu_irq`=0. Set ENABLE=0x0008 -> `cpu_irq`=1 next cycle. Drop `irq_in[3]` -> `cpu_irq`=0 two cycles later. W1C to bit 3 has no effect while the line is high.
- **Reset mid-operation**: with PENDING=0x00FF and `cpu_irq`=1, assert `reset` for 1 cycle while `irq_in[1]` is held high -> all registers and outputs 0. After release, no edge event on line 1 and PENDING stays 0 until a fresh rising edge.
- **FORCE and reserved**: write 0x0080 to addr 5 with EDGE_SEL[7]=1 -> PENDING=0x0080. Read addr 6 -> 0x0000. With NUM_IRQ=8, write 0xFFFF to ENABLE -> reads back 0x00FF.

Source files
------------

// File: rtl/sys_irq_ctrl.sv
// rtl/sys_irq_ctrl.sv - interrupt aggregator with edge/level latching, masking and a 16-bit register slave
module sys_irq_ctrl #(
    parameter int NUM_IRQ = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [15:0]         writedata,
    output logic [15:0]         readdata,
    input  logic [NUM_IRQ-1:0]  irq_in,
    output logic                cpu_irq,
    output logic [3:0]          irq_id
);

    localparam int W = NUM_IRQ;

    localparam logic [2:0] ADDR_PENDING  = 3'd0;
    localparam logic [2:0] ADDR_ENABLE   = 3'd1;
    localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE   = 3'd3;
    localparam logic [2:0] ADDR_OVERRUN  = 3'd4;
    localparam logic [2:0] ADDR_FORCE    = 3'd5;

    logic [W-1:0] pending;
    logic [W-1:0] enable;
    logic [W-1:0] edge_sel;
    logic [W-1:0] overrun;
    logic [W-1:0] irq_d;
    // Cleared by reset so the first active cycle only reloads irq_d and cannot see a false edge.
    logic         armed;

    logic         wr_en;
    logic [W-1:0] wdata;
    logic         unused_wd;

    logic [W-1:0] rise;
    logic [W-1:0] pend_clr;
    logic [W-1:0] force_set;
    logic [W-1:0] pending_next;
    logic [W-1:0] ovr_clr;
    logic [W-1:0] overrun_next;
    logic [W-1:0] masked;
    logic [3:0]   act_id;
    logic [15:0]  rd_mux;

    assign wr_en     = chipselect & ~write_n;
    assign wdata     = writedata[W-1:0];
    assign unused_wd = ^writedata;

    always_comb begin
        rise      = armed ? (irq_in & ~irq_d) : '0;
        pend_clr  = (wr_en && address == ADDR_PENDING) ? wdata : '0;
        force_set = (wr_en && address == ADDR_FORCE)   ? wdata : '0;
        ovr_clr   = (wr_en && address == ADDR_OVERRUN) ? wdata : '0;

        // Set terms are OR-ed after the clear so a same-cycle set always wins.
        pending_next = (edge_sel & ((rise | force_set) | (pending & ~pend_clr)))
                     | (~edge_sel & irq_in);
        overrun_next = (rise & pending & edge_sel) | (overrun & ~ovr_clr);
    end

    always_comb begin
        masked = pending & enable;
        act_id = 4'd0;
        for (int i = W - 1; i >= 0; i--) begin
            if (masked[i]) begin
                act_id = 4'(i);
            end
        end
    end

    always_comb begin
        rd_mux = 16'h0000;
        case (address)
            ADDR_PENDING:  rd_mux = 16'(pending);
            ADDR_ENABLE:   rd_mux = 16'(enable);
            ADDR_EDGE_SEL: rd_mux = 16'(edge_sel);
            ADDR_ACTIVE:   rd_mux = {|masked, 11'b0, act_id};
            ADDR_OVERRUN:  rd_mux = 16'(overrun);
            default:       rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            enable   <= '0;
            edge_sel <= '0;
            overrun  <= '0;
            irq_d    <= '0;
            armed    <= 1'b0;
            cpu_irq  <= 1'b0;
            irq_id   <= 4'd0;
            readdata <= 16'h0000;
        end else begin
            irq_d    <= irq_in;
            armed    <= 1'b1;
            pending  <= pending_next;
            overrun  <= overrun_next;
            if (wr_en && address == ADDR_ENABLE) begin
                enable <= wdata;
            end
            if (wr_en && address == ADDR_EDGE_SEL) begin
                edge_sel <= wdata;
            end
            cpu_irq  <= |masked;
            irq_id   <= act_id;
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_sys_irq_ctrl.sv
// tb/tb_sys_irq_ctrl.sv - self-checking bench for sys_irq_ctrl
module tb_sys_irq_ctrl;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [7:0]  irq_in;
    logic        cpu_irq;
    logic [3:0]  irq_id;

    int n_checks;
    int n_fail;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    sys_irq_ctrl #(.NUM_IRQ(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .cpu_irq    (cpu_irq),
        .irq_id     (irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string tag);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        tick();
        chipselect = 1'b0;
        check(tag_q.pop_front(), readdata, exp_q.pop_front());
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'h0000;
        irq_in     = 8'h00;
        tick();
        tick();
        reset = 1'b0;

        check("rst_cpu_irq", 16'(cpu_irq), 16'h0000);
        check("rst_irq_id", 16'(irq_id), 16'h0000);
        check("rst_readdata", readdata, 16'h0000);
        for (int a = 0; a < 6; a++) begin
            rd(3'(a), 16'h0000, $sformatf("rst_reg%0d", a));
        end

        // edge latch and clear
        wr(3'd2, 16'h0001);
        wr(3'd1, 16'h0001);
        irq_in = 8'h01;
        tick();
        irq_in = 8'h00;
        check("edge_cpu_irq_k", 16'(cpu_irq), 16'h0000);
        tick();
        check("edge_cpu_irq_k1", 16'(cpu_irq), 16'h0001);
        check("edge_irq_id", 16'(irq_id), 16'h0000);
        rd(3'd0, 16'h0001, "edge_pending");
        wr(3'd0, 16'h0001);
        check("edge_w1c_n", 16'(cpu_irq), 16'h0001);
        tick();
        check("edge_w1c_n1", 16'(cpu_irq), 16'h0000);

        // priority
        wr(3'd2, 16'h0024);
        wr(3'd1, 16'h0024);
        irq_in = 8'h24;
        tick();
        irq_in = 8'h00;
        tick();
        check("prio_irq_id", 16'(irq_id), 16'h0002);
        rd(3'd3, 16'h8002, "prio_active_2");
        wr(3'd0, 16'h0004);
        rd(3'd3, 16'h8005, "prio_active_5");
        check("prio_irq_id5", 16'(irq_id), 16'h0005);
        wr(3'd0, 16'h0020);
        rd(3'd3, 16'h0000, "prio_active_none");
        check("prio_cpu_irq", 16'(cpu_irq), 16'h0000);

        // overrun and set-wins
        wr(3'd2, 16'h0001);
        wr(3'd1, 16'h0001);
        for (int p = 0; p < 2; p++) begin
            irq_in = 8'h01;
            tick();
            irq_in = 8'h00;
            tick();
        end
        rd(3'd4, 16'h0001, "ovr_overrun");
        rd(3'd0, 16'h0001, "ovr_pending");
        irq_in = 8'h01;
        wr(3'd0, 16'h0001);
        irq_in = 8'h00;
        rd(3'd0, 16'h0001, "ovr_set_wins");
        wr(3'd0, 16'h0001);
        wr(3'd4, 16'h0001);
        rd(3'd4, 16'h0000, "ovr_cleared");
        rd(3'd0, 16'h0000, "ovr_pend_cleared");

        // level mode and mask
        wr(3'd2, 16'h0000);
        wr(3'd1, 16'h0000);
        irq_in = 8'h08;
        tick();
        tick();
        rd(3'd0, 16'h0008, "lvl_pending");
        check("lvl_masked", 16'(cpu_irq), 16'h0000);
        wr(3'd1, 16'h0008);
        check("lvl_en_n", 16'(cpu_irq), 16'h0000);
        tick();
        check("lvl_en_n1", 16'(cpu_irq), 16'h0001);
        check("lvl_irq_id", 16'(irq_id), 16'h0003);
        wr(3'd0, 16'h0008);
        rd(3'd0, 16'h0008, "lvl_w1c_ignored");
        irq_in = 8'h00;
        tick();
        check("lvl_drop_1", 16'(cpu_irq), 16'h0001);
        tick();
        check("lvl_drop_2", 16'(cpu_irq), 16'h0000);

        // reset mid-operation
        wr(3'd1, 16'h00FF);
        irq_in = 8'hFF;
        tick();
        tick();
        rd(3'd0, 16'h00FF, "mid_pending_ff");
        check("mid_cpu_irq", 16'(cpu_irq), 16'h0001);
        irq_in = 8'h02;
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
        check("mid_rst_cpu_irq", 16'(cpu_irq), 16'h0000);
        check("mid_rst_irq_id", 16'(irq_id), 16'h0000);
        check("mid_rst_readdata", readdata, 16'h0000);
        rd(3'd1, 16'h0000, "mid_rst_enable");
        rd(3'd2, 16'h0000, "mid_rst_edge_sel");
        wr(3'd2, 16'h0002);
        wr(3'd0, 16'h0002);
        tick();
        tick();
        rd(3'd0, 16'h0000, "mid_no_edge_high");
        rd(3'd4, 16'h0000, "mid_no_overrun");
        irq_in = 8'h00;
        tick();
        irq_in = 8'h02;
        tick();
        rd(3'd0, 16'h0002, "mid_fresh_edge");
        irq_in = 8'h00;
        wr(3'd0, 16'h0002);

        // force and reserved
        wr(3'd2, 16'h0080);
        wr(3'd5, 16'h0080);
        rd(3'd0, 16'h0080, "force_pending");
        wr(3'd5, 16'h0001);
        rd(3'd0, 16'h0080, "force_level_ignored");
        rd(3'd5, 16'h0000, "force_reads_0");
        rd(3'd6, 16'h0000, "reserved_6");
        wr(3'd6, 16'hFFFF);
        rd(3'd7, 16'h0000, "reserved_7");
        wr(3'd1, 16'hFFFF);
        rd(3'd1, 16'h00FF, "enable_width");
        check("force_cpu_irq", 16'(cpu_irq), 16'h0001);
        check("force_irq_id", 16'(irq_id), 16'h0007);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
